// File: rtl/seq_shift_left.sv
// rtl/seq_shift_left.sv - multi-cycle left shifter, one barrel stage per clock
// Optional rotate mode: define SHL_ROTATE_EN to add the rot input.
module seq_shift_left #(
    parameter int WIDTH = 8,
    localparam int SW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SW-1:0]    B,
`ifdef SHL_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [SW-1:0] K_LAST = SW'(SW - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [SW-1:0]    amt;
    logic [SW-1:0]    k;
    logic             c_acc;
`ifdef SHL_ROTATE_EN
    logic             rot_q;
`endif

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] spill;
    logic [WIDTH-1:0] stage_val;

    // spill holds the bits leaving the MSB end; its LSB is the stage carry
    // and, in rotate mode, it refills the vacated LSBs.
    always_comb begin
        shifted   = acc << (1 << k);
        spill     = acc >> (WIDTH - (1 << k));
        stage_val = shifted;
`ifdef SHL_ROTATE_EN
        if (rot_q) begin
            stage_val = shifted | spill;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            acc   <= '0;
            amt   <= '0;
            k     <= '0;
            c_acc <= 1'b0;
`ifdef SHL_ROTATE_EN
            rot_q <= 1'b0;
`endif
            res   <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // The done-pulse cycle is still closing the previous op.
                    if (start && !done) begin
                        acc   <= A;
                        amt   <= B;
                        k     <= '0;
                        c_acc <= 1'b0;
`ifdef SHL_ROTATE_EN
                        rot_q <= rot;
`endif
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (amt[k]) begin
                        acc   <= stage_val;
                        c_acc <= spill[0];
                    end
                    k <= k + 1'b1;
                    if (k == K_LAST) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    res   <= acc;
                    carry <= c_acc;
                    zero  <= (acc == '0);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    k     <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_left.sv
// tb/tb_seq_shift_left.sv - directed self-checking bench for seq_shift_left
module tb_seq_shift_left;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [2:0] B;
`ifdef SHL_ROTATE_EN
    logic       rot;
`endif
    logic [7:0] res;
    logic       carry;
    logic       zero;
    logic       busy;
    logic       done;

    int total  = 0;
    int passed = 0;
    int lat;
    int bcnt;
    int dcnt;

    seq_shift_left #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
`ifdef SHL_ROTATE_EN
        .rot   (rot),
`endif
        .res   (res),
        .carry (carry),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic issue(input logic [7:0] a, input logic [2:0] b, input logic r);
        A     = a;
        B     = b;
`ifdef SHL_ROTATE_EN
        rot   = r;
`else
        if (r) $display("rot requested without rotate build");
`endif
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called 1ns after the accepting edge; lat counts edges until done.
    task automatic wait_done(output int l, output int bc);
        l  = 0;
        bc = 0;
        for (int i = 1; i <= 10; i++) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            if (done) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [7:0] a, input logic [2:0] b,
                             input logic r, input logic [7:0] eres, input logic ecarry,
                             input logic ezero);
        issue(a, b, r);
        wait_done(lat, bcnt);
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_res"}, res, eres);
        chk({tag, "_carry"}, carry, ecarry);
        chk({tag, "_zero"}, zero, ezero);
        @(posedge clk);
        #1 chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
`ifdef SHL_ROTATE_EN
        rot   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res", res, 0);
        chk("rst_carry", carry, 0);
        chk("rst_zero", zero, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // rst and start together: rst wins
        A = 8'h81; B = 3'd1; start = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", busy, 0);
        @(posedge clk);
        #1;

        issue(8'h81, 3'd1, 1'b0);
        wait_done(lat, bcnt);
        chk("op81_lat", lat, 4);
        chk("op81_busy_cycles", bcnt, 4);
        chk("op81_res", res, 8'h02);
        chk("op81_carry", carry, 1);
        chk("op81_zero", zero, 0);
        chk("op81_busy_at_done", busy, 0);
        @(posedge clk);
        #1 chk("op81_done_pulse", done, 0);

        run_check("opFF", 8'hFF, 3'd7, 1'b0, 8'h80, 1'b1, 1'b0);

        // B=0 keeps full latency; previous result held while busy
        issue(8'h5A, 3'd0, 1'b0);
        chk("hold_res0", res, 8'h80);
        chk("hold_carry0", carry, 1);
        @(posedge clk);
        #1 chk("hold_res1", res, 8'h80);
        @(posedge clk);
        #1 chk("hold_res2", res, 8'h80);
        wait_done(lat, bcnt);
        chk("op5A_lat", lat, 2);
        chk("op5A_res", res, 8'h5A);
        chk("op5A_carry", carry, 0);
        chk("op5A_zero", zero, 0);
        @(posedge clk);
        #1;

        run_check("op10", 8'h10, 3'd4, 1'b0, 8'h00, 1'b1, 1'b1);

        // start while busy is ignored
        issue(8'h01, 3'd3, 1'b0);
        A = 8'hFF; B = 3'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bcnt);
        chk("busy_ign_lat", lat, 3);
        chk("busy_ign_res", res, 8'h08);
        chk("busy_ign_carry", carry, 0);

        // start in the done cycle is ignored, accepted one cycle later
        A = 8'hE0; B = 3'd2; start = 1'b1;
        @(posedge clk);
        #1 chk("done_cyc_ign_busy", busy, 0);
        chk("done_cyc_ign_done", done, 0);
        @(posedge clk);
        #1 start = 1'b0;
        chk("after_done_accept", busy, 1);
        wait_done(lat, bcnt);
        chk("opE0_lat", lat, 4);
        chk("opE0_res", res, 8'h80);
        chk("opE0_carry", carry, 1);
        @(posedge clk);
        #1;

        // reset mid-SHIFT aborts with no done
        issue(8'h0F, 3'd2, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_res", res, 0);
        chk("abort_carry", carry, 0);
        chk("abort_zero", zero, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);

        run_check("op03", 8'h03, 3'd1, 1'b0, 8'h06, 1'b0, 1'b0);

`ifdef SHL_ROTATE_EN
        run_check("rot81", 8'h81, 3'd1, 1'b1, 8'h03, 1'b1, 1'b0);
        run_check("rotF0", 8'hF0, 3'd4, 1'b1, 8'h0F, 1'b1, 1'b0);
        run_check("rot5A_b0", 8'h5A, 3'd0, 1'b1, 8'h5A, 1'b0, 1'b0);
        run_check("norot81", 8'h81, 3'd1, 1'b0, 8'h02, 1'b1, 1'b0);
        run_check("norot10", 8'h10, 3'd4, 1'b0, 8'h00, 1'b1, 1'b1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
